// File: rtl/act_pkg.sv
// rtl/act_pkg.sv - shared activation-stage types and LUT geometry
package act_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    LOAD,
    COMMIT
  } state_t;

  localparam logic [1:0] ACT_MODE_RELU = 2'b10;
  localparam int         Q_ENCODE_MAX  = 7;

  localparam int LUT_WIDTH    = 24;
  localparam int ADDR_WIDTH   = 4;
  localparam int LUT_DEPTH    = 16;
  localparam int DRAIN_CYCLES = 3;
  localparam int Q_WIDTH      = 4;

endpackage

// File: rtl/act_drain_cnt.sv
// rtl/act_drain_cnt.sv - idle-cycle down-counter, restarts whenever a datapath beat is seen
module act_drain_cnt #(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_en,
  input  logic i_activity,
  output logic o_zero
);

  localparam int CW = $clog2(DRAIN_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load || (i_en && i_activity)) begin
      cnt_d = CW'(DRAIN_CYCLES);
    end else if (i_en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/act_lut_cfg_ctrl.sv
// rtl/act_lut_cfg_ctrl.sv - activation LUT reload controller with drain, write-through and atomic commit
module act_lut_cfg_ctrl #(
  parameter int LUT_WIDTH    = act_pkg::LUT_WIDTH,
  parameter int ADDR_WIDTH   = act_pkg::ADDR_WIDTH,
  parameter int LUT_DEPTH    = act_pkg::LUT_DEPTH,
  parameter int DRAIN_CYCLES = act_pkg::DRAIN_CYCLES,
  parameter int Q_WIDTH      = act_pkg::Q_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cfg_start,
  input  logic                  i_cfg_abort,
  input  logic [Q_WIDTH-1:0]    i_cfg_q_encode,
  input  logic [1:0]            i_cfg_act_mode,
  input  logic                  i_coe_valid,
  input  logic [LUT_WIDTH-1:0]  i_coe_data,
  output logic                  o_coe_ready,
  input  logic                  i_dp_valid,
  output logic                  o_dp_hold,
  output logic [LUT_WIDTH-1:0]  o_lut_wdata,
  output logic [ADDR_WIDTH-1:0] o_lut_addr,
  output logic                  o_lut_we,
  output logic                  o_lut_en,
  output logic [Q_WIDTH-1:0]    o_q_encode,
  output logic [1:0]            o_act_mode,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  import act_pkg::*;

  localparam logic [Q_WIDTH-1:0]    QMAX     = Q_WIDTH'(Q_ENCODE_MAX);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(LUT_DEPTH - 1);

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [Q_WIDTH-1:0]    shadow_q_encode_q;
  logic [1:0]            shadow_act_mode_q;

  logic start_ok;
  logic drain_zero;
  logic accept;

  assign start_ok = (state_q == IDLE) && i_cfg_start && (i_cfg_q_encode <= QMAX);
  assign accept   = (state_q == LOAD) && o_coe_ready && i_coe_valid;

  act_drain_cnt #(
    .DRAIN_CYCLES(DRAIN_CYCLES)
  ) u_drain_cnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (start_ok),
    .i_en       (state_q == DRAIN),
    .i_activity (i_dp_valid),
    .o_zero     (drain_zero)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q           <= IDLE;
      idx_q             <= '0;
      shadow_q_encode_q <= '0;
      shadow_act_mode_q <= '0;
      o_coe_ready       <= 1'b0;
      o_dp_hold         <= 1'b0;
      o_lut_wdata       <= '0;
      o_lut_addr        <= '0;
      o_lut_we          <= 1'b0;
      o_lut_en          <= 1'b0;
      o_q_encode        <= '0;
      o_act_mode        <= '0;
      o_busy            <= 1'b0;
      o_done            <= 1'b0;
      o_err             <= 1'b0;
    end else begin
      o_lut_we <= 1'b0;
      o_lut_en <= 1'b0;
      o_done   <= 1'b0;
      o_err    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // Abort is meaningless here, so a simultaneous start still goes ahead.
          if (i_cfg_start) begin
            if (start_ok) begin
              shadow_q_encode_q <= i_cfg_q_encode;
              shadow_act_mode_q <= i_cfg_act_mode;
              state_q           <= DRAIN;
              o_dp_hold         <= 1'b1;
              o_busy            <= 1'b1;
            end else begin
              o_err <= 1'b1;
            end
          end
        end
        DRAIN, LOAD: begin
          if (i_cfg_abort) begin
            state_q     <= IDLE;
            o_coe_ready <= 1'b0;
            o_dp_hold   <= 1'b0;
            o_busy      <= 1'b0;
            o_err       <= 1'b1;
          end else begin
            if (i_cfg_start) begin
              o_err <= 1'b1;
            end
            // A beat arriving on the zero cycle would still be in flight, so wait it out.
            if ((state_q == DRAIN) && drain_zero && !i_dp_valid) begin
              state_q     <= LOAD;
              idx_q       <= '0;
              o_coe_ready <= 1'b1;
            end
            if (accept) begin
              o_lut_we    <= 1'b1;
              o_lut_en    <= 1'b1;
              o_lut_addr  <= idx_q;
              o_lut_wdata <= i_coe_data;
              if (idx_q == LAST_IDX) begin
                state_q     <= COMMIT;
                o_coe_ready <= 1'b0;
                o_q_encode  <= shadow_q_encode_q;
                o_act_mode  <= shadow_act_mode_q;
                o_done      <= 1'b1;
              end else begin
                idx_q <= idx_q + ADDR_WIDTH'(1);
              end
            end
          end
        end
        COMMIT: begin
          if (i_cfg_start) begin
            o_err <= 1'b1;
          end
          state_q   <= IDLE;
          o_dp_hold <= 1'b0;
          o_busy    <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_act_lut_cfg_ctrl.sv
// tb/tb_act_lut_cfg_ctrl.sv - table-driven scoreboard bench for act_lut_cfg_ctrl
module tb_act_lut_cfg_ctrl;

  import act_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cfg_start = 1'b0;
  logic        cfg_abort = 1'b0;
  logic [3:0]  cfg_q = '0;
  logic [1:0]  cfg_mode = '0;
  logic        coe_valid = 1'b0;
  logic [23:0] coe_data = '0;
  logic        dp_valid = 1'b0;

  logic        o_coe_ready;
  logic        o_dp_hold;
  logic [23:0] o_lut_wdata;
  logic [3:0]  o_lut_addr;
  logic        o_lut_we;
  logic        o_lut_en;
  logic [3:0]  o_q_encode;
  logic [1:0]  o_act_mode;
  logic        o_busy;
  logic        o_done;
  logic        o_err;

  always #5 clk = ~clk;

  act_lut_cfg_ctrl dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_cfg_start    (cfg_start),
    .i_cfg_abort    (cfg_abort),
    .i_cfg_q_encode (cfg_q),
    .i_cfg_act_mode (cfg_mode),
    .i_coe_valid    (coe_valid),
    .i_coe_data     (coe_data),
    .o_coe_ready    (o_coe_ready),
    .i_dp_valid     (dp_valid),
    .o_dp_hold      (o_dp_hold),
    .o_lut_wdata    (o_lut_wdata),
    .o_lut_addr     (o_lut_addr),
    .o_lut_we       (o_lut_we),
    .o_lut_en       (o_lut_en),
    .o_q_encode     (o_q_encode),
    .o_act_mode     (o_act_mode),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_err          (o_err)
  );

  typedef struct {
    logic [3:0] addr;
    logic [23:0] data;
  } wr_t;

  typedef struct {
    logic [3:0] q;
    logic [1:0] mode;
    int         dp;
    bit         bubble;
    int         abort_at;
    int         dup_at;
    bit         abort_w_start;
    int         exp_lat;
    logic [3:0] exp_q;
    logic [1:0] exp_mode;
  } vec_t;

  wr_t  exp_wr[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   wr_total = 0;
  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && o_lut_we) begin
      wr_total++;
      if (exp_wr.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", o_lut_addr, o_lut_wdata);
      end else begin
        wr_t e;
        e = exp_wr.pop_front();
        check("lut_write", {o_lut_en, o_lut_addr, o_lut_wdata}, {1'b1, e.addr, e.data});
      end
    end
  end

  task automatic run_reload(input vec_t v, input logic [23:0] base);
    int n, k, done_cyc, wr0;
    bit gap, hold_ok, aborted;
    n = 0; k = 0; done_cyc = -1; gap = 0; hold_ok = 1; aborted = 0;
    wr0 = wr_total;
    @(negedge clk);
    cfg_start = 1'b1; cfg_q = v.q; cfg_mode = v.mode; cfg_abort = v.abort_w_start;
    while (done_cyc < 0 && !aborted && k < 100) begin
      @(negedge clk);
      k++;
      cfg_start = 1'b0; cfg_abort = 1'b0;
      if (!o_dp_hold) hold_ok = 0;
      if (v.dup_at > 0 && k == v.dup_at + 1) check("dup_start_err", o_err, 1);
      if (o_done) begin
        done_cyc = k;
      end else begin
        dp_valid = (k <= v.dp);
        if (k == v.dup_at) begin
          cfg_start = 1'b1; cfg_q = 4'd1; cfg_mode = 2'd0;
        end
        if (v.abort_at >= 0 && n == v.abort_at && o_coe_ready) begin
          cfg_abort = 1'b1; coe_valid = 1'b1; coe_data = base + 24'(n);
          aborted = 1;
        end else begin
          coe_valid = (n < LUT_DEPTH) && !gap;
          coe_data  = base + 24'(n);
          gap = 0;
          if (coe_valid && o_coe_ready) begin
            exp_wr.push_back('{4'(n), coe_data});
            n++;
            gap = v.bubble;
          end
        end
      end
    end
    if (aborted) begin
      @(negedge clk);
      cfg_abort = 1'b0; coe_valid = 1'b0;
      check("abort_err", o_err, 1);
      check("abort_idle", {o_busy, o_dp_hold, o_coe_ready}, 0);
    end else begin
      coe_valid = 1'b0; dp_valid = 1'b0;
      check("done_latency", done_cyc, v.exp_lat);
      check("hold_during_reload", hold_ok, 1);
      @(negedge clk);
      check("release", {o_busy, o_dp_hold, o_done}, 0);
    end
    repeat (3) @(negedge clk);
    check("q_encode", o_q_encode, v.exp_q);
    check("act_mode", o_act_mode, v.exp_mode);
    check("write_count", wr_total - wr0, aborted ? v.abort_at : LUT_DEPTH);
    check("scoreboard_empty", exp_wr.size(), 0);
  endtask

  initial begin
    int nn;
    vecs[0] = '{4'd3, ACT_MODE_RELU, 0, 1'b0, -1, 0, 1'b0, 21, 4'd3, ACT_MODE_RELU};
    vecs[1] = '{4'd5, 2'd1,          2, 1'b0, -1, 0, 1'b0, 23, 4'd5, 2'd1};
    vecs[2] = '{4'd7, 2'd3,          0, 1'b1, -1, 0, 1'b0, 36, 4'd7, 2'd3};
    vecs[3] = '{4'd2, 2'd0,          0, 1'b0,  5, 0, 1'b0, -1, 4'd7, 2'd3};
    vecs[4] = '{4'd0, ACT_MODE_RELU, 1, 1'b0, -1, 0, 1'b0, 22, 4'd0, ACT_MODE_RELU};
    vecs[5] = '{4'd4, 2'd1,          0, 1'b0, -1, 8, 1'b0, 21, 4'd4, 2'd1};
    vecs[6] = '{4'd6, ACT_MODE_RELU, 0, 1'b0, -1, 0, 1'b1, 21, 4'd6, ACT_MODE_RELU};
    vecs[7] = '{4'd1, 2'd1,          0, 1'b0, 15, 0, 1'b0, -1, 4'd6, ACT_MODE_RELU};

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {o_coe_ready, o_dp_hold, o_lut_wdata, o_lut_addr, o_lut_we, o_lut_en,
                            o_q_encode, o_act_mode, o_busy, o_done, o_err}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_reload(vecs[i], 24'h000100 + 24'(i * 24'h1000));
    end

    for (int bad = 8; bad <= 9; bad++) begin
      @(negedge clk);
      cfg_start = 1'b1; cfg_q = 4'(bad); cfg_mode = 2'd1;
      @(negedge clk);
      cfg_start = 1'b0;
      check("illegal_q_err", o_err, 1);
      check("illegal_q_idle", {o_busy, o_dp_hold}, 0);
      @(negedge clk);
      check("illegal_q_err_pulse", o_err, 0);
      check("illegal_q_cfg_kept", {o_q_encode, o_act_mode}, {4'd6, ACT_MODE_RELU});
    end

    nn = 0;
    @(negedge clk);
    cfg_start = 1'b1; cfg_q = 4'd5; cfg_mode = 2'd1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      cfg_start = 1'b0; coe_valid = 1'b1; coe_data = 24'hABC000 + 24'(nn);
      if (o_coe_ready) begin
        exp_wr.push_back('{4'(nn), coe_data});
        nn++;
      end
    end
    @(negedge clk);
    coe_valid = 1'b0;
    check("pre_reset_busy", o_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {o_coe_ready, o_dp_hold, o_lut_wdata, o_lut_addr, o_lut_we, o_lut_en,
                                  o_q_encode, o_act_mode, o_busy, o_done, o_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("reset_scoreboard_empty", exp_wr.size(), 0);
    exp_wr.delete();
    run_reload(vecs[0], 24'h0F0F00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
